// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage add/sub/adc/sbb/cmp/clc unit with a persistent {C,Z,V,N} flag register.
// Latency 2 cycles accept-to-out_valid, 1 op/cycle; flags_q updates on the accept edge only.
// Backpressure: S2 holds until out_ready, S1 holds behind a stalled S2, in_ready = !s1_valid || s1_advance.
// Optional: define ADDSUB_SATURATE_EN to clamp signed-overflowing add/sub/adc/sbb results.
module addsub_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  output logic             err,
  output logic [3:0]       flags_q
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ADC = 3'b010;
  localparam logic [2:0] OP_SBB = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;
  localparam logic [2:0] OP_CLC = 3'b101;
  localparam int         MSB    = WIDTH - 1;

  // Stage 1 holds the computed result; beat_q says whether it becomes an output beat.
  logic             s1_valid_q, s1_valid_d;
  logic             s1_beat_q,  s1_beat_d;
  logic [WIDTH-1:0] s1_res_q,   s1_res_d;
  logic [3:0]       s1_flg_q,   s1_flg_d;
  logic             s1_err_q,   s1_err_d;
  // Stage 2 is the output register.
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_res_q,   s2_res_d;
  logic [3:0]       s2_flg_q,   s2_flg_d;
  logic             s2_err_q,   s2_err_d;
  logic [3:0]       flags_d;

  logic             s1_advance;
  logic             accept;
  logic             cin;
  logic             is_sub;
  logic             is_cmp;
  logic             is_clc;
  logic             is_rsvd;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res_raw;
  logic [WIDTH-1:0] res_fin;
  logic             c_raw;
  logic             v_raw;
  logic [3:0]       arith_flg;

  assign s1_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s1_advance;
  assign accept     = in_valid && in_ready;

  assign cin     = flags_q[3];
  assign is_cmp  = (select == OP_CMP);
  assign is_clc  = (select == OP_CLC);
  assign is_rsvd = select[2] & select[1];

  // WIDTH+1 bit sum; the top bit is carry-out for adds and borrow for subtracts.
  always_comb begin
    is_sub = 1'b0;
    sum    = '0;
    case (select)
      OP_ADD: sum = {1'b0, a} + {1'b0, b};
      OP_ADC: sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SUB, OP_CMP: begin
        is_sub = 1'b1;
        sum    = {1'b0, a} - {1'b0, b};
      end
      OP_SBB: begin
        is_sub = 1'b1;
        sum    = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      end
      default: sum = '0;
    endcase
  end

  assign res_raw = sum[MSB:0];
  assign c_raw   = sum[WIDTH];
  // Signed overflow: operands of the effective same sign produced a result of the other sign.
  assign v_raw   = is_sub ? ((a[MSB] != b[MSB]) && (res_raw[MSB] != a[MSB]))
                          : ((a[MSB] == b[MSB]) && (res_raw[MSB] != a[MSB]));

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflow direction follows the sign of a; cmp keeps the raw difference for its flags.
  assign res_fin = (v_raw && !is_cmp) ? (a[MSB] ? SAT_NEG : SAT_POS) : res_raw;
`else
  assign res_fin = res_raw;
`endif

  assign arith_flg = {c_raw, (res_fin == '0), v_raw, res_fin[MSB]};

  // Next-state: S1->S2 transfer when S2 can take it, new op into S1 on accept, flag register update.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_beat_d  = s1_beat_q;
    s1_res_d   = s1_res_q;
    s1_flg_d   = s1_flg_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_res_d   = s2_res_q;
    s2_flg_d   = s2_flg_q;
    s2_err_d   = s2_err_q;
    flags_d    = flags_q;

    if (s1_advance) begin
      // No-output ops vanish here instead of taking an S2 slot.
      s2_valid_d = s1_valid_q && s1_beat_q;
      if (s1_valid_q && s1_beat_q) begin
        s2_res_d = s1_res_q;
        s2_flg_d = s1_flg_q;
        s2_err_d = s1_err_q;
      end
      s1_valid_d = 1'b0;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_beat_d  = !is_cmp && !is_clc;
      if (is_rsvd) begin
        s1_res_d = '0;
        s1_flg_d = '0;
        s1_err_d = 1'b1;
      end else begin
        s1_res_d = res_fin;
        s1_flg_d = arith_flg;
        s1_err_d = 1'b0;
      end
      if (is_clc) begin
        flags_d = {1'b0, flags_q[2:0]};
      end else if (!is_rsvd) begin
        flags_d = arith_flg;
      end
    end
  end

  // State registers with synchronous flush of both stages and the flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_beat_q  <= 1'b0;
      s1_res_q   <= '0;
      s1_flg_q   <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_res_q   <= '0;
      s2_flg_q   <= '0;
      s2_err_q   <= 1'b0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_beat_q  <= s1_beat_d;
      s1_res_q   <= s1_res_d;
      s1_flg_q   <= s1_flg_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_res_q   <= s2_res_d;
      s2_flg_q   <= s2_flg_d;
      s2_err_q   <= s2_err_d;
      flags_q    <= flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_res_q;
  assign carry     = s2_flg_q[3];
  assign zero      = s2_flg_q[2];
  assign overflow  = s2_flg_q[1];
  assign negative  = s2_flg_q[0];
  assign err       = s2_err_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: directed literal checks plus randomized traffic against an arithmetic reference model.
// Model tracks the flag register and an expected-beat queue; one negedge monitor compares every beat.
// Backpressure: out_ready is toggled; held beats must stay stable and none may be lost or duplicated.
`timescale 1ns/1ps
module tb_addsub_pipe;

  localparam int W = 32;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ADC = 3'd2, SBB = 3'd3,
                         CMP = 3'd4, CLC = 3'd5;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    select;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  dout;
  logic          carry, zero, overflow, negative, err;
  logic [3:0]    flags_q;

  addsub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .carry(carry), .zero(zero), .overflow(overflow),
    .negative(negative), .err(err), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    logic        e;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       got_q[$];
  logic [3:0]  mflags = 4'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          acc_cnt = 0;
  logic        hold_vld = 1'b0;
  logic [63:0] held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on 64-bit values.
  task automatic model_accept(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned ux, uy, c;
    longint          sx, sy, ss;
    logic [31:0]     r;
    logic            cf, vf;
    beat_t           bt;
    ux = {32'b0, x};
    uy = {32'b0, y};
    c  = {63'b0, mflags[3]};
    sx = $signed(x);
    sy = $signed(y);
    ss = 0;
    cf = 1'b0;
    r  = '0;
    case (op)
      ADD: begin ss = sx + sy; cf = (ux + uy) > 64'hFFFF_FFFF; r = 32'(ux + uy); end
      SUB, CMP: begin ss = sx - sy; cf = ux < uy; r = 32'(ux - uy); end
      ADC: begin ss = sx + sy + longint'(c); cf = (ux + uy + c) > 64'hFFFF_FFFF; r = 32'(ux + uy + c); end
      SBB: begin ss = sx - sy - longint'(c); cf = ux < (uy + c); r = 32'(ux - uy - c); end
      CLC: begin mflags[3] = 1'b0; return; end
      default: begin
        bt.r = '0; bt.f = '0; bt.e = 1'b1;
        exp_q.push_back(bt);
        return;
      end
    endcase
    vf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
`ifdef ADDSUB_SATURATE_EN
    if (vf && op != CMP) r = (ss > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    mflags = {cf, (r == 32'd0), vf, r[31]};
    if (op != CMP) begin
      bt.r = r; bt.f = mflags; bt.e = 1'b0;
      exp_q.push_back(bt);
    end
  endtask

  // Single compare process: flags register, every output beat, and stability while stalled.
  always @(negedge clk) begin
    logic [63:0] cur;
    beat_t       e;
    beat_t       g;
    if (reset) begin
      exp_q.delete();
      mflags   = 4'b0;
      hold_vld = 1'b0;
    end else begin
      chk("flags_q", {60'b0, flags_q}, {60'b0, mflags});
      cur = {27'b0, dout, carry, zero, overflow, negative, err};
      if (out_valid) begin
        if (hold_vld) chk("hold_stable", cur, held);
        if (out_ready) begin
          g.r = dout; g.f = {carry, zero, overflow, negative}; g.e = err;
          got_q.push_back(g);
          if (exp_q.size() == 0) begin
            chk("spurious_beat", cur, 64'hDEAD);
          end else begin
            e = exp_q.pop_front();
            chk("beat", cur, {27'b0, e.r, e.f, e.e});
          end
          hold_vld = 1'b0;
        end else begin
          held     = cur;
          hold_vld = 1'b1;
        end
      end else begin
        if (hold_vld) chk("held_beat_dropped", 64'd0, 64'd1);
        hold_vld = 1'b0;
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        model_accept(select, a, b);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Call #1 after a rising edge; returns #1 after the accepting edge so calls chain back-to-back.
  task automatic issue(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int n;
    n = 0;
    select = op; a = x; b = y; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("issue_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    reset = 1'b1; in_valid = 1'b0; select = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_out", {32'b0, dout}, 64'd0);
    chk("rst_flags_err", {59'b0, carry, zero, overflow, negative, err}, 64'd0);
    chk("rst_flags_q", {60'b0, flags_q}, 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", {63'b0, in_ready}, 64'd1);

    // add 3+88: latency and value.
    step();
    in_valid = 1'b1; select = ADD; a = 32'd3; b = 32'd88;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1", {63'b0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat_cycle2", {63'b0, out_valid}, 64'd1);
    chk("add_3_88", {28'b0, dout, carry, zero, overflow, negative}, {28'b0, 32'd91, 4'b0000});
    wait_drain();

    // Subtraction cases.
    got_q.delete();
    step();
    issue(SUB, 32'd1, 32'd1);
    issue(SUB, 32'd82, 32'd149);
    wait_drain();
    chk("sub_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("sub_1_1", {28'b0, got_q[0].r, got_q[0].f}, {28'b0, 32'd0, 4'b0100});
      chk("sub_82_149", {28'b0, got_q[1].r, got_q[1].f}, {28'b0, 32'hFFFF_FFBD, 4'b1001});
    end

    // Signed overflow.
    got_q.delete();
    step();
    issue(ADD, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_drain();
    if (got_q.size() == 1) begin
`ifdef ADDSUB_SATURATE_EN
      chk("add_ovf", {28'b0, got_q[0].r, got_q[0].f}, {28'b0, 32'h7FFF_FFFF, 4'b0010});
`else
      chk("add_ovf", {28'b0, got_q[0].r, got_q[0].f}, {28'b0, 32'hFFFF_FFFE, 4'b0011});
`endif
    end else chk("add_ovf_count", 64'(got_q.size()), 64'd1);

    // Carry chaining, back-to-back.
    got_q.delete();
    step();
    issue(ADD, 32'hFFFF_FFFF, 32'd1);
    issue(ADC, 32'd0, 32'd0);
    issue(CLC, 32'd0, 32'd0);
    issue(ADC, 32'd0, 32'd0);
    issue(CMP, 32'd5, 32'd7);
    wait_drain();
    chk("chain_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("chain_add", {28'b0, got_q[0].r, got_q[0].f}, {28'b0, 32'd0, 4'b1100});
      chk("chain_adc1", {32'b0, got_q[1].r}, 64'd1);
      chk("chain_adc0", {28'b0, got_q[2].r, got_q[2].f}, {28'b0, 32'd0, 4'b0100});
    end
    chk("cmp_flags_q", {60'b0, flags_q}, {60'b0, 4'b1001});

    // Backpressure: 4 ops while out_ready is low for 5 cycles.
    got_q.delete();
    step();
    out_ready = 1'b0;
    a0 = acc_cnt;
    fork
      begin
        issue(ADD, 32'd10, 32'd20);
        issue(SUB, 32'd5, 32'd9);
        issue(ADC, 32'd1, 32'd1);
        issue(ADD, 32'd0, 32'd0);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_accepts", 64'(acc_cnt - a0), 64'd2);
        chk("bp_in_ready", {63'b0, in_ready}, 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4) begin
      chk("bp_r0", {32'b0, got_q[0].r}, 64'd30);
      chk("bp_r1", {32'b0, got_q[1].r}, 64'hFFFF_FFFC);
      chk("bp_r2", {32'b0, got_q[2].r}, 64'd3);
      chk("bp_r3", {32'b0, got_q[3].r}, 64'd0);
    end

    // Reset with both stages full.
    step();
    out_ready = 1'b0;
    issue(ADD, 32'd1, 32'd1);
    issue(SUB, 32'd3, 32'd3);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_flags_q", {60'b0, flags_q}, 64'd0);
    got_q.delete();
    step();
    issue(ADD, 32'd2, 32'd2);
    wait_drain();
    if (got_q.size() == 1)
      chk("post_rst_add", {28'b0, got_q[0].r, got_q[0].f}, {28'b0, 32'd4, 4'b0000});
    else chk("post_rst_count", 64'(got_q.size()), 64'd1);

    // Randomized traffic, including reserved opcodes, stalls and occasional resets.
    step();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      select    = 3'($urandom_range(0, 7));
      a         = pick();
      b         = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 599) == 0);
      step();
    end
    in_valid = 1'b0; reset = 1'b0; out_ready = 1'b1;
    wait_drain();
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
